// File: rtl/uart_transmitter_pkg.sv
// Shared constants for the UART transmitter: FIFO geometry, LCR bit positions,
// transmitter state codes and bit-period tick reload values.
package uart_transmitter_pkg;

  localparam int UART_FIFO_WIDTH     = 8;
  localparam int UART_FIFO_COUNTER_W = 5;

  // LCR bit positions ([1:0] is the word-length field)
  localparam int UART_LC_BITS = 0;
  localparam int UART_LC_SB   = 2;
  localparam int UART_LC_PE   = 3;
  localparam int UART_LC_EP   = 4;
  localparam int UART_LC_SP   = 5;
  localparam int UART_LC_BC   = 6;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } tx_state_e;

  // Tick counter reloads: a bit of N ticks ends on the tick that finds 0
  localparam logic [4:0] TICKS_BIT_M1 = 5'd15;
  localparam logic [4:0] TICKS_1P5_M1 = 5'd23;
  localparam logic [4:0] TICKS_2_M1   = 5'd31;

endpackage

// File: rtl/uart_transmitter.sv
// UART serial transmit engine: pops one FIFO character per frame and shifts it
// out LSB first with 16x oversampled bit timing, optional parity and break.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int FIFO_WIDTH     = UART_FIFO_WIDTH,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [7:0]                lcr,
  input  logic [FIFO_WIDTH-1:0]     tf_data,
  input  logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic                      tf_pop,
  output logic                      stx_pad_o,
  output logic [2:0]                tstate,
  output logic                      tx_busy
);

  tx_state_e  state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [5:0] cfg_q, cfg_d;
  logic       par_q, par_d;
  logic       pop_q, pop_d;
  logic       stx_q, stx_d;
  logic       busy_q, busy_d;
  logic       serial;
  logic [4:0] stop_m1;
  logic       unused_lcr;

  assign unused_lcr = lcr[7];

  function automatic logic parity_bit(input logic [7:0] data, input logic [5:0] cfg);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - cfg[UART_LC_BITS+:2]);
    if (cfg[UART_LC_SP]) return ~cfg[UART_LC_EP];
    if (cfg[UART_LC_EP]) return ^(data & mask);
    return ~^(data & mask);
  endfunction

  // 1.5 stop bits only exist for 5-bit words; other lengths get 2
  assign stop_m1 = !cfg_q[UART_LC_SB]               ? TICKS_BIT_M1 :
                   (cfg_q[UART_LC_BITS+:2] == 2'b00) ? TICKS_1P5_M1 : TICKS_2_M1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    pop_d   = 1'b0;
    case (state_q)
      UART_TX_IDLE: begin
        // pop strobe occupies one IDLE clk; data is taken as it leaves the FIFO
        if (pop_q) begin
          shift_d = tf_data[7:0];
          cfg_d   = lcr[5:0];
          par_d   = parity_bit(tf_data[7:0], lcr[5:0]);
          tick_d  = TICKS_BIT_M1;
          state_d = UART_TX_START;
        end else if (tf_count != '0) begin
          pop_d = 1'b1;
        end
      end
      UART_TX_START, UART_TX_DATA, UART_TX_PARITY, UART_TX_STOP: begin
        if (enable) begin
          if (tick_q != 5'd0) begin
            tick_d = tick_q - 5'd1;
          end else begin
            tick_d = TICKS_BIT_M1;
            case (state_q)
              UART_TX_START: begin
                state_d = UART_TX_DATA;
                bit_d   = {1'b0, cfg_q[UART_LC_BITS+:2]} + 3'd4;
              end
              UART_TX_DATA: begin
                shift_d = shift_q >> 1;
                if (bit_q != 3'd0) begin
                  bit_d = bit_q - 3'd1;
                end else if (cfg_q[UART_LC_PE]) begin
                  state_d = UART_TX_PARITY;
                end else begin
                  state_d = UART_TX_STOP;
                  tick_d  = stop_m1;
                end
              end
              UART_TX_PARITY: begin
                state_d = UART_TX_STOP;
                tick_d  = stop_m1;
              end
              default: state_d = UART_TX_IDLE;
            endcase
          end
        end
      end
      default: state_d = UART_TX_IDLE;
    endcase
  end

  // Line level follows the next state so stx changes on the same edge as tstate
  always_comb begin
    serial = 1'b1;
    case (state_d)
      UART_TX_START:  serial = 1'b0;
      UART_TX_DATA:   serial = shift_d[0];
      UART_TX_PARITY: serial = par_d;
      default:        serial = 1'b1;
    endcase
    stx_d  = serial & ~lcr[UART_LC_BC];
    busy_d = (state_d != UART_TX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      pop_q   <= 1'b0;
      stx_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      pop_q   <= pop_d;
      stx_q   <= stx_d;
      busy_q  <= busy_d;
    end
  end

  assign tf_pop    = pop_q;
  assign stx_pad_o = stx_q;
  assign tstate    = state_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: queued FIFO model, frame reference
// model in bit/tick terms, and a monitor that follows the line tick by tick.
module tb_uart_transmitter;
  import uart_transmitter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] lcr = 8'h03;
  logic [7:0] tf_data = 8'h00;
  logic [4:0] tf_count = 5'd0;
  logic       tf_pop, stx_pad_o, tx_busy;
  logic [2:0] tstate;

  uart_transmitter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lcr(lcr),
    .tf_data(tf_data), .tf_count(tf_count), .tf_pop(tf_pop),
    .stx_pad_o(stx_pad_o), .tstate(tstate), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [5:0] cfg;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo[$];
  logic [7:0] push_q[$];
  int checks = 0, errors = 0, pop_cnt = 0, en_mode = 0, cyc = 0;
  int seg_lv[12], seg_tk[12], seg_st[12], seg_n;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame as (level, ticks, state) segments derived from the line rules
  function automatic void build_frame(input logic [7:0] d, input logic [5:0] c);
    int wl, ones;
    wl = int'(c[1:0]) + 5;
    ones = 0;
    seg_n = 0;
    seg_lv[seg_n] = 0; seg_tk[seg_n] = 16; seg_st[seg_n] = 1; seg_n++;
    for (int i = 0; i < wl; i++) begin
      seg_lv[seg_n] = int'(d[i]); seg_tk[seg_n] = 16; seg_st[seg_n] = 2; seg_n++;
      ones += int'(d[i]);
    end
    if (c[3]) begin
      if (c[5])      seg_lv[seg_n] = c[4] ? 0 : 1;
      else if (c[4]) seg_lv[seg_n] = ones % 2;
      else           seg_lv[seg_n] = 1 - (ones % 2);
      seg_tk[seg_n] = 16; seg_st[seg_n] = 3; seg_n++;
    end
    seg_lv[seg_n] = 1;
    seg_tk[seg_n] = !c[2] ? 16 : (wl == 5 ? 24 : 32);
    seg_st[seg_n] = 4;
    seg_n++;
  endfunction

  task automatic push(input logic [7:0] d);
    frame_t f;
    f.d = d;
    f.cfg = lcr[5:0];
    push_q.push_back(d);
    exp_q.push_back(f);
  endtask

  // Transmit FIFO model
  initial begin
    logic pop_now;
    forever begin
      @(negedge clk);
      pop_now = (tf_pop === 1'b1);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fifo.delete();
        push_q.delete();
      end else begin
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
        while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
      end
      tf_count = 5'(fifo.size());
      tf_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Baud tick: 0 = every clk, 1 = random ~1/4, 2 = every 4th clk
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       enable = 1'b1;
        1:       enable = ($urandom_range(0, 3) == 0);
        default: enable = (cyc % 4 == 0);
      endcase
      cyc++;
    end
  end

  // Pop legality
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tf_pop === 1'b1) begin
        pop_cnt++;
        chk(tf_count != 0 && tstate == 3'd0, "pop_rule", int'(tstate), 0);
      end
    end
  end

  // Monitor: on each pop, follow the expected frame tick by tick
  initial begin
    frame_t f;
    bit aborted, exp_pop, brk, lv;
    int ticks, bad;
    exp_pop = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pop = 0;
        continue;
      end
      if (exp_pop) begin
        chk(tf_pop === 1'b1, "b2b_idle_gap", int'(tf_pop), 1);
        exp_pop = 0;
      end
      if (tf_pop === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pop", 1, 0);
        end else begin
          f = exp_q.pop_front();
          chk(tf_data == f.d, "pop_data", int'(tf_data), int'(f.d));
          build_frame(f.d, f.cfg);
          brk = lcr[6];
          aborted = 0;
          for (int k = 0; k < seg_n && !aborted; k++) begin
            ticks = 0;
            bad = 0;
            lv = (seg_lv[k] != 0);
            while (ticks < seg_tk[k] && !aborted) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1;
              end else begin
                if (stx_pad_o !== (lv & ~brk) || tstate !== 3'(seg_st[k]) ||
                    tf_pop !== 1'b0 || tx_busy !== 1'b1) bad++;
                brk = lcr[6];
                if (enable) ticks++;
              end
            end
            if (!aborted)
              chk(bad == 0, $sformatf("frame_%02h_seg%0d_state%0d", f.d, k, seg_st[k]), bad, 0);
          end
          if (!aborted) begin
            @(negedge clk);
            if (rst_n) begin
              chk(tstate == 3'd0 && !tx_busy && !tf_pop && stx_pad_o == ~brk, "stop_to_idle",
                  int'({tstate, tx_busy, tf_pop, stx_pad_o}), int'({5'b0, ~brk}));
              exp_pop = (tf_count != 0);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || tf_count != 0 || push_q.size() != 0 || tf_pop) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(n < 8000, "idle_timeout", n, 8000);
    chk(exp_q.size() == 0, "frames_pending", exp_q.size(), 0);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    while (tstate !== s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 5000, $sformatf("wait_state%0d", s), n, 5000);
  endtask

  initial begin
    int p0, nb;
    logic [5:0] r6;
    logic [7:0] r8;

    repeat (2) @(negedge clk);
    chk({stx_pad_o, tf_pop, tstate, tx_busy} == 6'b100000, "reset_values",
        int'({stx_pad_o, tf_pop, tstate, tx_busy}), 32);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // directed frames, enable held high
    en_mode = 0;
    @(posedge clk); #1;
    lcr = 8'h03; push(8'hA5); wait_idle();
    @(posedge clk); #1;
    lcr = 8'h1A; push(8'h41); wait_idle();
    @(posedge clk); #1;
    lcr = 8'h0A; push(8'h41); wait_idle();
    @(posedge clk); #1;
    lcr = 8'h3C; push(8'h1F); wait_idle();
    @(posedge clk); #1;
    lcr = 8'h2C; push(8'h1F); wait_idle();
    @(posedge clk); #1;
    lcr = 8'h07; push(8'hC3); wait_idle();

    // back-to-back, enable every 4th clk
    en_mode = 2;
    p0 = pop_cnt;
    @(posedge clk); #1;
    lcr = 8'h03; push(8'h11); push(8'h22); push(8'h33);
    wait_idle();
    chk(pop_cnt - p0 == 3, "b2b_pop_count", pop_cnt - p0, 3);

    // break during DATA, released during STOP
    en_mode = 0;
    @(posedge clk); #1;
    lcr = 8'h03; push(8'hFF);
    wait_state(3'd2);
    @(posedge clk); #1 lcr[6] = 1'b1;
    repeat (2) @(negedge clk);
    chk(stx_pad_o == 1'b0 && tstate == 3'd2, "break_low", int'({stx_pad_o, tstate}), 2);
    wait_state(3'd4);
    @(posedge clk); #1 lcr[6] = 1'b0;
    push(8'h5A);
    wait_idle();

    // lcr changes mid-frame must not disturb the latched frame
    @(posedge clk); #1;
    lcr = 8'h1B; push(8'h96);
    wait_state(3'd2);
    r6 = 6'($urandom);
    @(posedge clk); #1 lcr = {2'b00, r6};
    wait_idle();

    // random batches
    for (int b = 0; b < 6; b++) begin
      en_mode = $urandom_range(0, 2);
      r6 = 6'($urandom);
      nb = $urandom_range(1, 4);
      @(posedge clk); #1;
      lcr = {2'b00, r6};
      for (int i = 0; i < nb; i++) begin
        r8 = 8'($urandom);
        push(r8);
      end
      wait_idle();
    end

    // asynchronous reset mid-frame
    en_mode = 0;
    @(posedge clk); #1;
    lcr = 8'h03; push(8'h00);
    wait_state(3'd2);
    repeat (20) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk({stx_pad_o, tf_pop, tstate, tx_busy} == 6'b100000, "reset_mid_frame",
        int'({stx_pad_o, tf_pop, tstate, tx_busy}), 32);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    p0 = pop_cnt;
    repeat (30) @(negedge clk);
    chk(pop_cnt == p0, "no_pop_after_reset", pop_cnt - p0, 0);
    chk(stx_pad_o == 1'b1 && tstate == 3'd0, "idle_after_reset", int'({stx_pad_o, tstate}), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
